// File: rtl/fetch_controller_if.sv
// Instruction memory port: request/ready for the address,
// rvalid/rdata for the returned word.
interface fetch_controller_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_controller.sv
// IF stage sequencer: owns the PC, issues one fetch at a time,
// buffers the returned word and drives the IF/ID register controls.
module fetch_controller #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_id,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    fetch_controller_if.master mem,
    output logic [WIDTH-1:0] inst_if,
    output logic [WIDTH-1:0] pc_if,
    output logic [WIDTH-1:0] pc_plus_4_if,
    output logic             stall_if,
    output logic             flush_if
);
    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

    localparam logic [WIDTH-1:0] FOUR  = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN = ~WIDTH'(3);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] req_pc;
    logic             buf_valid;
    logic [WIDTH-1:0] buf_inst;
    logic [WIDTH-1:0] buf_pc;

    logic consume;
    logic req;
    logic fire;
    logic load;

    assign consume = buf_valid & ~stall_id & ~redirect_valid;
    assign req     = (state == REQ) & (~buf_valid | consume)
                   & ~redirect_valid;
    assign fire    = req & mem.imem_ready;
    // A response is only kept if no redirect lands in the same cycle.
    assign load    = (state == WAIT) & mem.imem_rvalid & ~redirect_valid;

    assign mem.imem_req  = req;
    assign mem.imem_addr = pc;

    assign inst_if      = buf_inst;
    assign pc_if        = buf_pc;
    assign pc_plus_4_if = buf_pc + FOUR;
    assign stall_if     = stall_id & ~redirect_valid;
    assign flush_if     = redirect_valid | (~buf_valid & ~stall_id);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= REQ;
        else     state <= state_n;
    end

    // Next-state: WAIT leaves on any rvalid; a redirect with no
    // response yet must still swallow the stale one in DROP.
    always_comb begin
        state_n = state;
        unique case (state)
            REQ:  if (fire) state_n = WAIT;
            WAIT: begin
                if (mem.imem_rvalid)     state_n = REQ;
                else if (redirect_valid) state_n = DROP;
            end
            DROP: if (mem.imem_rvalid) state_n = REQ;
            default: state_n = REQ;
        endcase
    end

    // PC, in-flight address and one-entry instruction buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            req_pc    <= '0;
            buf_valid <= 1'b0;
            buf_inst  <= '0;
            buf_pc    <= '0;
        end else begin
            if (fire) begin
                req_pc <= pc;
                pc     <= pc + FOUR;
            end
            if (redirect_valid) begin
                pc <= redirect_pc & ALIGN;
            end
            if (redirect_valid) begin
                buf_valid <= 1'b0;
            end else if (load) begin
                buf_valid <= 1'b1;
                buf_inst  <= mem.imem_rdata;
                buf_pc    <= req_pc;
            end else if (consume) begin
                buf_valid <= 1'b0;
            end
        end
    end
endmodule
